// File: rtl/wb_pkg.sv
// Shared writeback-stage types: source and load-funct3 encodings, buffer occupancy, RV32 entry.
package wb_pkg;
  localparam int WB_XLEN = 32;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PCIMM = 2'd2, WB_PC4 = 2'd3} wb_sel_e;
  typedef enum logic [2:0] {LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101} load_f3_e;
  typedef enum logic [1:0] {CNT_EMPTY = 2'd0, CNT_ONE = 2'd1, CNT_FULL = 2'd2} cnt_e;

  typedef struct packed {
    logic [WB_XLEN-1:0] data;
    logic [4:0]         rd;
    logic               wen;
  } wb_entry_t;

  // x0 is hardwired, so a write to it is never issued.
  function automatic logic rd_write_en(input logic wen, input logic [4:0] rd, input logic legal);
    return wen && (rd != 5'd0) && legal;
  endfunction
endpackage

// File: rtl/wb_select_stage_if.sv
// Upstream/downstream handshake bundle of the writeback stage; slave is the stage side.
interface wb_select_stage_if #(
  parameter int XLEN = 32,
  parameter int NSRC = 4
);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  logic                 IN_VALID;
  logic                 IN_READY;
  logic [SELW-1:0]      WB_SEL;
  logic [NSRC*XLEN-1:0] SRC_DATA;
  logic [2:0]           LOAD_F3;
  logic [1:0]           ADDR_LSB;
  logic [4:0]           RD_ADDR;
  logic                 RD_WEN;
  logic                 OUT_VALID;
  logic                 OUT_READY;
  logic [XLEN-1:0]      REG_WRITE;
  logic [4:0]           RD_ADDR_OUT;
  logic                 RD_WEN_OUT;
  logic                 SEL_ERR;

  modport master (
    output IN_VALID, WB_SEL, SRC_DATA, LOAD_F3, ADDR_LSB, RD_ADDR, RD_WEN, OUT_READY,
    input  IN_READY, OUT_VALID, REG_WRITE, RD_ADDR_OUT, RD_WEN_OUT, SEL_ERR
  );
  modport slave (
    input  IN_VALID, WB_SEL, SRC_DATA, LOAD_F3, ADDR_LSB, RD_ADDR, RD_WEN, OUT_READY,
    output IN_READY, OUT_VALID, REG_WRITE, RD_ADDR_OUT, RD_WEN_OUT, SEL_ERR
  );
endinterface

// File: rtl/wb_load_ext.sv
// Combinational sub-word load extender for the memory result source.
module wb_load_ext
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] data_i,
  input  logic [2:0]      f3_i,
  input  logic [1:0]      lsb_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data_i[{lsb_i, 3'b000} +: 8];
    // Halfword alignment comes from bit 1 only; a misaligned bit 0 is dropped.
    half_sel = lsb_i[1] ? data_i[31:16] : data_i[15:0];
    data_o   = data_i;
    case (f3_i)
      LB:      data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      LBU:     data_o = {{(XLEN-8){1'b0}}, byte_sel};
      LH:      data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      LHU:     data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = data_i;
    endcase
  end
endmodule

// File: rtl/wb_select_stage.sv
// Writeback select stage: source mux, optional load extension (WB_LOAD_EXT_EN),
// and a 2-entry valid/ready buffer in front of the register file.
module wb_select_stage
  import wb_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NSRC = 4
) (
  input  logic               CLK,
  input  logic               RSTN,
  wb_select_stage_if.slave   bus
);
  localparam int SELW = (NSRC > 1) ? $clog2(NSRC) : 1;

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic [4:0]      rd;
    logic            wen;
  } entry_t;

  logic            sel_legal;
  logic [XLEN-1:0] mem_data, mux_data;
  entry_t          new_entry, head;
  entry_t          mem_q [2];
  logic            hd_q, tl_q;
  cnt_e            state_q, state_d;
  logic            sel_err_q;
  logic            in_rdy, out_vld, push, pop;

  assign sel_legal = ({{(32-SELW){1'b0}}, bus.WB_SEL} < 32'(NSRC));

`ifdef WB_LOAD_EXT_EN
  wb_load_ext #(.XLEN(XLEN)) u_load_ext (
    .data_i (bus.SRC_DATA[XLEN +: XLEN]),
    .f3_i   (bus.LOAD_F3),
    .lsb_i  (bus.ADDR_LSB),
    .data_o (mem_data)
  );
`else
  logic unused_ld;
  assign mem_data  = bus.SRC_DATA[XLEN +: XLEN];
  assign unused_ld = ^{bus.LOAD_F3, bus.ADDR_LSB};
`endif

  // Out-of-range selects match no source and fall through to zero data.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.WB_SEL == SELW'(i))
        mux_data = (i == int'(WB_MEM)) ? mem_data : bus.SRC_DATA[i*XLEN +: XLEN];
    end
  end

  assign new_entry.data = mux_data;
  assign new_entry.rd   = bus.RD_ADDR;
  assign new_entry.wen  = rd_write_en(bus.RD_WEN, bus.RD_ADDR, sel_legal);

  assign in_rdy  = (state_q != CNT_FULL);
  assign out_vld = (state_q != CNT_EMPTY);
  assign push    = bus.IN_VALID && in_rdy;
  assign pop     = out_vld && bus.OUT_READY;

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= CNT_EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CNT_EMPTY: if (push) state_d = CNT_ONE;
      CNT_ONE: begin
        if (push && !pop)      state_d = CNT_FULL;
        else if (pop && !push) state_d = CNT_EMPTY;
      end
      CNT_FULL:  if (pop) state_d = CNT_ONE;
      default:   state_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      hd_q      <= 1'b0;
      tl_q      <= 1'b0;
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      sel_err_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[tl_q] <= new_entry;
        tl_q        <= ~tl_q;
      end
      if (pop) hd_q <= ~hd_q;
      sel_err_q <= sel_err_q | (push & ~sel_legal);
    end
  end

  // Outputs are gated by valid so an idle stage never shows stale head contents.
  assign head            = mem_q[hd_q];
  assign bus.IN_READY    = in_rdy;
  assign bus.OUT_VALID   = out_vld;
  assign bus.REG_WRITE   = out_vld ? head.data : '0;
  assign bus.RD_ADDR_OUT = out_vld ? head.rd   : 5'd0;
  assign bus.RD_WEN_OUT  = out_vld & head.wen;
  assign bus.SEL_ERR     = sel_err_q;
endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench: directed vector table, stall/reset/illegal-select sequences, random vs queue model.
module tb_wb_select_stage;
  logic CLK, RSTN;
  int   n_cmp, n_bad;

  wb_select_stage_if #(.XLEN(32), .NSRC(4)) if4 ();
  wb_select_stage_if #(.XLEN(32), .NSRC(3)) if3 ();

  wb_select_stage #(.XLEN(32), .NSRC(4)) u4 (.CLK(CLK), .RSTN(RSTN), .bus(if4));
  wb_select_stage #(.XLEN(32), .NSRC(3)) u3 (.CLK(CLK), .RSTN(RSTN), .bus(if3));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       nm;
    int          sel;
    logic [31:0] src;
    int          f3;
    int          lsb;
    int          rd;
    bit          wen;
    logic [31:0] exp_d;
    bit          exp_w;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          rd;
    bit          w;
  } exp_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference result straight from the load rules: shift/mask, then subtract to sign-extend.
  function automatic logic [31:0] ref_data(input int sel, input logic [31:0] v, input int f3,
                                           input int lsb, input int nsrc);
    if (sel >= nsrc) return 32'd0;
    if (sel != 1) return v;
`ifdef WB_LOAD_EXT_EN
    begin
      logic [31:0] b, h;
      b = (v >> (8 * lsb)) & 32'hFF;
      h = (v >> (16 * (lsb / 2))) & 32'hFFFF;
      case (f3)
        0: return (b >= 32'd128) ? b - 32'd256 : b;
        4: return b;
        1: return (h >= 32'd32768) ? h - 32'h10000 : h;
        5: return h;
        default: return v;
      endcase
    end
`else
    return v;
`endif
  endfunction

  task automatic drive4(input int sel, input logic [31:0] v, input int f3, input int lsb,
                        input int rd, input bit wen);
    logic [127:0] s;
    s = {$urandom, $urandom, $urandom, $urandom};
    s[sel*32 +: 32] = v;
    if4.SRC_DATA = s;
    if4.WB_SEL   = 2'(sel);
    if4.LOAD_F3  = 3'(f3);
    if4.ADDR_LSB = 2'(lsb);
    if4.RD_ADDR  = 5'(rd);
    if4.RD_WEN   = wen;
    if4.IN_VALID = 1'b1;
  endtask

`ifdef WB_LOAD_EXT_EN
  localparam logic [31:0] E_LB = 32'hFFFF_FF81, E_LBU = 32'h0000_007F;
  localparam logic [31:0] E_LH = 32'hFFFF_80FF, E_LHU = 32'h0000_80FF;
`else
  localparam logic [31:0] E_LB = 32'h80FF_7F81, E_LBU = 32'h80FF_7F81;
  localparam logic [31:0] E_LH = 32'h80FF_7F81, E_LHU = 32'h80FF_7F81;
`endif

  initial begin
    vec_t vt[10];
    exp_t q[$];
    logic [31:0] a_d [3];

    n_cmp = 0;
    n_bad = 0;
    vt[0] = '{"alu",      0, 32'h0000_1234, 0, 0, 5,  1'b1, 32'h0000_1234, 1'b1};
    vt[1] = '{"lb_0",     1, 32'h80FF_7F81, 0, 0, 6,  1'b1, E_LB,          1'b1};
    vt[2] = '{"lbu_1",    1, 32'h80FF_7F81, 4, 1, 7,  1'b1, E_LBU,         1'b1};
    vt[3] = '{"lh_2",     1, 32'h80FF_7F81, 1, 2, 8,  1'b1, E_LH,          1'b1};
    vt[4] = '{"lhu_2",    1, 32'h80FF_7F81, 5, 2, 9,  1'b1, E_LHU,         1'b1};
    vt[5] = '{"lw_3",     1, 32'h80FF_7F81, 2, 3, 10, 1'b1, 32'h80FF_7F81, 1'b1};
    vt[6] = '{"pcimm",    2, 32'hDEAD_BEE0, 0, 0, 31, 1'b1, 32'hDEAD_BEE0, 1'b1};
    vt[7] = '{"pc4_nowe", 3, 32'h0000_1008, 0, 0, 1,  1'b0, 32'h0000_1008, 1'b0};
    vt[8] = '{"rd0",      0, 32'h0000_0055, 0, 0, 0,  1'b1, 32'h0000_0055, 1'b0};
    vt[9] = '{"lh_3_odd", 1, 32'h80FF_7F81, 1, 3, 12, 1'b1, E_LH,          1'b1};

    RSTN = 1'b0;
    if4.IN_VALID = 1'b0; if4.OUT_READY = 1'b1; if4.WB_SEL = '0; if4.SRC_DATA = '0;
    if4.LOAD_F3 = '0; if4.ADDR_LSB = '0; if4.RD_ADDR = '0; if4.RD_WEN = 1'b0;
    if3.IN_VALID = 1'b0; if3.OUT_READY = 1'b1; if3.WB_SEL = '0; if3.SRC_DATA = '0;
    if3.LOAD_F3 = '0; if3.ADDR_LSB = '0; if3.RD_ADDR = '0; if3.RD_WEN = 1'b0;

    repeat (2) @(negedge CLK);
    chk("rst_out_valid", 32'(if4.OUT_VALID), 32'd0);
    chk("rst_in_ready",  32'(if4.IN_READY),  32'd1);
    chk("rst_reg_write", if4.REG_WRITE,      32'd0);
    chk("rst_rd_out",    32'(if4.RD_ADDR_OUT), 32'd0);
    chk("rst_wen_out",   32'(if4.RD_WEN_OUT),  32'd0);
    chk("rst_sel_err",   32'(if3.SEL_ERR),     32'd0);
    RSTN = 1'b1;

    // Directed table: one push at a time with the sink always ready.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      chk({vt[i].nm, "_pre_valid"}, 32'(if4.OUT_VALID), 32'd0);
      drive4(vt[i].sel, vt[i].src, vt[i].f3, vt[i].lsb, vt[i].rd, vt[i].wen);
      @(negedge CLK);
      if4.IN_VALID = 1'b0;
      chk({vt[i].nm, "_valid"}, 32'(if4.OUT_VALID),   32'd1);
      chk({vt[i].nm, "_data"},  if4.REG_WRITE,        vt[i].exp_d);
      chk({vt[i].nm, "_rd"},    32'(if4.RD_ADDR_OUT), 32'(vt[i].rd));
      chk({vt[i].nm, "_wen"},   32'(if4.RD_WEN_OUT),  32'(vt[i].exp_w));
    end

    // Stall: A, B accepted, C held upstream, then drained in order.
    a_d[0] = 32'hA000_000A; a_d[1] = 32'hB000_000B; a_d[2] = 32'hC000_000C;
    @(negedge CLK);
    if4.OUT_READY = 1'b0;
    drive4(0, a_d[0], 0, 0, 11, 1'b1);
    @(negedge CLK);
    chk("stall_a_valid", 32'(if4.OUT_VALID), 32'd1);
    chk("stall_rdy_one", 32'(if4.IN_READY),  32'd1);
    drive4(0, a_d[1], 0, 0, 12, 1'b1);
    @(negedge CLK);
    chk("stall_rdy_full", 32'(if4.IN_READY), 32'd0);
    drive4(0, a_d[2], 0, 0, 13, 1'b1);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("stall_hold_rdy",  32'(if4.IN_READY),    32'd0);
      chk("stall_hold_data", if4.REG_WRITE,        a_d[0]);
      chk("stall_hold_rd",   32'(if4.RD_ADDR_OUT), 32'd11);
      chk("stall_hold_wen",  32'(if4.RD_WEN_OUT),  32'd1);
    end
    if4.OUT_READY = 1'b1;
    @(negedge CLK);
    chk("drain_b_data", if4.REG_WRITE,        a_d[1]);
    chk("drain_b_rd",   32'(if4.RD_ADDR_OUT), 32'd12);
    chk("drain_rdy",    32'(if4.IN_READY),    32'd1);
    @(negedge CLK);
    if4.IN_VALID = 1'b0;
    chk("drain_c_data", if4.REG_WRITE,        a_d[2]);
    chk("drain_c_rd",   32'(if4.RD_ADDR_OUT), 32'd13);
    @(negedge CLK);
    chk("drain_empty",  32'(if4.OUT_VALID),   32'd0);

    // Illegal select on the 3-source instance; flag is sticky.
    chk("selerr_pre", 32'(if3.SEL_ERR), 32'd0);
    if3.SRC_DATA = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    if3.WB_SEL = 2'd3; if3.RD_ADDR = 5'd4; if3.RD_WEN = 1'b1; if3.IN_VALID = 1'b1;
    @(negedge CLK);
    chk("selerr_valid", 32'(if3.OUT_VALID),  32'd1);
    chk("selerr_data",  if3.REG_WRITE,       32'd0);
    chk("selerr_wen",   32'(if3.RD_WEN_OUT), 32'd0);
    chk("selerr_flag",  32'(if3.SEL_ERR),    32'd1);
    if3.WB_SEL = 2'd2; if3.RD_ADDR = 5'd3;
    @(negedge CLK);
    if3.IN_VALID = 1'b0;
    chk("sel3_legal_data", if3.REG_WRITE,       32'h3333_3333);
    chk("sel3_legal_wen",  32'(if3.RD_WEN_OUT), 32'd1);
    repeat (3) @(negedge CLK);
    chk("selerr_sticky", 32'(if3.SEL_ERR), 32'd1);

    // Random traffic against a queue model of the 2-deep buffer.
    for (int c = 0; c < 400; c++) begin
      int sel, f3, lsb, rd;
      bit wen, iv, ordy;
      logic [31:0] v;
      exp_t e;
      chk("rnd_valid", 32'(if4.OUT_VALID), 32'(q.size() > 0));
      chk("rnd_ready", 32'(if4.IN_READY),  32'(q.size() < 2));
      if (q.size() > 0) begin
        chk("rnd_data", if4.REG_WRITE,        q[0].d);
        chk("rnd_rd",   32'(if4.RD_ADDR_OUT), 32'(q[0].rd));
        chk("rnd_wen",  32'(if4.RD_WEN_OUT),  32'(q[0].w));
      end else begin
        chk("rnd_idle_wen", 32'(if4.RD_WEN_OUT), 32'd0);
      end
      sel = $urandom_range(0, 3); f3 = $urandom_range(0, 7); lsb = $urandom_range(0, 3);
      rd = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 31);
      wen = 1'($urandom_range(0, 3) != 0);
      iv = 1'($urandom_range(0, 9) < 7);
      ordy = 1'($urandom_range(0, 9) < 6);
      v = $urandom;
      drive4(sel, v, f3, lsb, rd, wen);
      if4.IN_VALID = iv;
      if4.OUT_READY = ordy;
      e.d = ref_data(sel, v, f3, lsb, 4);
      e.rd = rd;
      e.w = wen && (rd != 0);
      if (iv && q.size() < 2) begin
        if (ordy && q.size() > 0) void'(q.pop_front());
        q.push_back(e);
      end else if (ordy && q.size() > 0) begin
        void'(q.pop_front());
      end
      @(negedge CLK);
    end
    chk("rnd_no_selerr", 32'(if4.SEL_ERR), 32'd0);

    // Async reset with two entries held.
    if4.OUT_READY = 1'b0;
    drive4(0, 32'h1111_0001, 0, 0, 20, 1'b1);
    repeat (3) @(negedge CLK);
    if4.IN_VALID = 1'b0;
    chk("prerst_valid", 32'(if4.OUT_VALID), 32'd1);
    chk("prerst_ready", 32'(if4.IN_READY),  32'd0);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_valid",   32'(if4.OUT_VALID),  32'd0);
    chk("arst_ready",   32'(if4.IN_READY),   32'd1);
    chk("arst_wen",     32'(if4.RD_WEN_OUT), 32'd0);
    chk("arst_data",    if4.REG_WRITE,       32'd0);
    chk("arst_sel_err", 32'(if3.SEL_ERR),    32'd0);
    if4.OUT_READY = 1'b1;
    @(negedge CLK);
    #2 RSTN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("postrst_idle", 32'(if4.OUT_VALID), 32'd0);
    end
    drive4(2, 32'h0BAD_F00D, 0, 0, 21, 1'b1);
    @(negedge CLK);
    if4.IN_VALID = 1'b0;
    chk("postrst_push_valid", 32'(if4.OUT_VALID), 32'd1);
    chk("postrst_push_data",  if4.REG_WRITE,      32'h0BAD_F00D);
    @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
